// File: rtl/bram_sdp_if.sv
// Write/read port bundle for bram_sdp: master drives the request side and slave returns rline.
interface bram_sdp_if #(
    parameter int unsigned LINE_WIDTH = 32,
    parameter int unsigned AW         = 9
);
    logic                  wen;
    logic [AW-1:0]         waddr;
    logic [LINE_WIDTH-1:0] wline;
    logic                  ren;
    logic [AW-1:0]         raddr;
    logic [LINE_WIDTH-1:0] rline;

    modport master (
        output wen, waddr, wline, ren, raddr,
        input  rline
    );

    modport slave (
        input  wen, waddr, wline, ren, raddr,
        output rline
    );
endinterface

// File: rtl/bram_sdp.sv
// Simple dual-port block RAM, one clock, registered read (latency 1), read-first on collision.
// Define BRAM_WRITE_BYPASS_EN to make same-address collisions write-first.
module bram_sdp #(
    parameter string       NAME       = "BRAM",
    parameter int unsigned LINE_WIDTH = 32,
    parameter int unsigned DEPTH      = 512
) (
    input logic       clk,
    input logic       rst,
    bram_sdp_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    // Zero at configuration: consumers such as the BTB read valid=0 until a line is written.
    logic [LINE_WIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic [LINE_WIDTH-1:0] rd_q;
    logic                  wr_ok_c;
    logic                  rd_ok_c;

    assign wr_ok_c = ({1'b0, bus.waddr} < DEPTH_L);
    assign rd_ok_c = ({1'b0, bus.raddr} < DEPTH_L);

    // Storage write port; reset deliberately leaves the array alone.
    always_ff @(posedge clk) begin
        if (bus.wen && wr_ok_c) begin
            mem[bus.waddr] <= bus.wline;
        end
    end

    // Output register; out-of-range reads return zero, ren=0 holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else if (bus.ren) begin
            rd_q <= rd_ok_c ? mem[bus.raddr] : '0;
        end
    end

`ifdef BRAM_WRITE_BYPASS_EN
    logic                  byp_q;
    logic [LINE_WIDTH-1:0] byp_line_q;
    logic                  hit_c;

    assign hit_c = bus.wen && wr_ok_c && (bus.waddr == bus.raddr);

    // Collision capture: remember that this read must return the concurrent write data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_q      <= 1'b0;
            byp_line_q <= '0;
        end else if (bus.ren) begin
            byp_q <= hit_c;
            if (hit_c) begin
                byp_line_q <= bus.wline;
            end
        end
    end

    assign bus.rline = byp_q ? byp_line_q : rd_q;
`else
    assign bus.rline = rd_q;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && ($isunknown(bus.wen) || $isunknown(bus.ren))) begin
            $error("%s: X/Z on wen/ren", NAME);
        end
    end
`endif

endmodule

// File: tb/tb_bram_sdp.sv
// Directed self-checking bench for bram_sdp: a 512-deep instance and a 100-deep instance.
module tb_bram_sdp;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bram_sdp_if #(.LINE_WIDTH(32), .AW(9)) a_if ();
    bram_sdp_if #(.LINE_WIDTH(32), .AW(7)) b_if ();

    bram_sdp #(.NAME("BRAM_A"), .LINE_WIDTH(32), .DEPTH(512)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    bram_sdp #(.NAME("BRAM_B"), .LINE_WIDTH(32), .DEPTH(100)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (a_if.rline !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", a_if.rline, 32'h0);
        end
        rst = 1'b0;
        tick();
        // Load a nonzero value so an asynchronous clear is observable.
        a_if.wen = 1'b1; a_if.waddr = 9'd1; a_if.wline = 32'hA5A5_A5A5;
        tick();
        a_if.wen = 1'b0; a_if.ren = 1'b1; a_if.raddr = 9'd1;
        tick();
        a_if.ren = 1'b0;
        checks++;
        if (a_if.rline !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL pre_reset_read: got %h want %h", a_if.rline, 32'hA5A5_A5A5);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (a_if.rline !== 32'h0) begin
            errors++;
            $display("FAIL async_clear: got %h want %h", a_if.rline, 32'h0);
        end
        // Read during reset is dropped; write during reset lands.
        a_if.ren = 1'b1; a_if.raddr = 9'd1;
        a_if.wen = 1'b1; a_if.waddr = 9'd2; a_if.wline = 32'h0000_0077;
        tick();
        checks++;
        if (a_if.rline !== 32'h0) begin
            errors++;
            $display("FAIL read_in_reset: got %h want %h", a_if.rline, 32'h0);
        end
        rst = 1'b0;
        a_if.wen = 1'b0;
        a_if.raddr = 9'd5;
        tick();
        checks++;
        if (a_if.rline !== 32'h0) begin
            errors++;
            $display("FAIL unwritten_read: got %h want %h", a_if.rline, 32'h0);
        end
        a_if.raddr = 9'd1;
        tick();
        checks++;
        if (a_if.rline !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL array_kept: got %h want %h", a_if.rline, 32'hA5A5_A5A5);
        end
        a_if.raddr = 9'd2;
        tick();
        checks++;
        if (a_if.rline !== 32'h0000_0077) begin
            errors++;
            $display("FAIL write_in_reset: got %h want %h", a_if.rline, 32'h0000_0077);
        end
        a_if.ren = 1'b0;
    endtask

    task automatic test_basic();
        a_if.wen = 1'b1; a_if.waddr = 9'd7; a_if.wline = 32'hDEAD_BEEF;
        tick();
        a_if.wen = 1'b0; a_if.ren = 1'b1; a_if.raddr = 9'd7;
        #3;
        checks++;
        if (a_if.rline !== 32'h0000_0077) begin
            errors++;
            $display("FAIL basic_not_early: got %h want %h", a_if.rline, 32'h0000_0077);
        end
        tick();
        checks++;
        if (a_if.rline !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL basic_read: got %h want %h", a_if.rline, 32'hDEAD_BEEF);
        end
        a_if.ren = 1'b0;
    endtask

    task automatic test_hold();
        a_if.wen = 1'b1; a_if.waddr = 9'd7; a_if.wline = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (a_if.rline !== 32'hDEAD_BEEF) begin
                errors++;
                $display("FAIL hold_%0d: got %h want %h", i, a_if.rline, 32'hDEAD_BEEF);
            end
        end
        a_if.wen = 1'b0; a_if.ren = 1'b1;
        tick();
        checks++;
        if (a_if.rline !== 32'h1234_5678) begin
            errors++;
            $display("FAIL hold_reread: got %h want %h", a_if.rline, 32'h1234_5678);
        end
        a_if.ren = 1'b0;
    endtask

    task automatic test_collision();
        logic [31:0] exp_col;
`ifdef BRAM_WRITE_BYPASS_EN
        exp_col = 32'h0000_2222;
`else
        exp_col = 32'h0000_1111;
`endif
        a_if.wen = 1'b1; a_if.waddr = 9'd3; a_if.wline = 32'h0000_1111;
        tick();
        a_if.wline = 32'h0000_2222; a_if.ren = 1'b1; a_if.raddr = 9'd3;
        tick();
        checks++;
        if (a_if.rline !== exp_col) begin
            errors++;
            $display("FAIL collision: got %h want %h", a_if.rline, exp_col);
        end
        a_if.wen = 1'b0;
        tick();
        checks++;
        if (a_if.rline !== 32'h0000_2222) begin
            errors++;
            $display("FAIL collision_reread: got %h want %h", a_if.rline, 32'h0000_2222);
        end
        // Writes elsewhere, with and without a read, leave rline alone.
        a_if.ren = 1'b0; a_if.wen = 1'b1; a_if.waddr = 9'd4; a_if.wline = 32'h0000_9999;
        tick();
        checks++;
        if (a_if.rline !== 32'h0000_2222) begin
            errors++;
            $display("FAIL other_write_idle: got %h want %h", a_if.rline, 32'h0000_2222);
        end
        a_if.ren = 1'b1; a_if.raddr = 9'd3; a_if.wline = 32'h0000_AAAA;
        tick();
        checks++;
        if (a_if.rline !== 32'h0000_2222) begin
            errors++;
            $display("FAIL other_write_read: got %h want %h", a_if.rline, 32'h0000_2222);
        end
        a_if.wen = 1'b0; a_if.ren = 1'b0;
    endtask

    task automatic test_back_to_back();
        a_if.wen = 1'b1;
        for (int i = 0; i < 512; i++) begin
            a_if.waddr = 9'(i);
            a_if.wline = 32'(i * 3);
            tick();
        end
        a_if.wen = 1'b0;
        a_if.ren = 1'b1;
        a_if.raddr = 9'd0;
        tick();
        for (int i = 1; i <= 512; i++) begin
            checks++;
            if (a_if.rline !== 32'((i - 1) * 3)) begin
                errors++;
                $display("FAIL stream_addr_%0d: got %h want %h", i - 1, a_if.rline, 32'((i - 1) * 3));
            end
            if (i < 512) begin
                a_if.raddr = 9'(i);
                tick();
            end
        end
        a_if.ren = 1'b0;
    endtask

    task automatic test_non_pow2();
        b_if.wen = 1'b1; b_if.waddr = 7'd20; b_if.wline = 32'h0000_ABCD;
        tick();
        b_if.waddr = 7'd99; b_if.wline = 32'h0000_0063;
        tick();
        b_if.waddr = 7'd120; b_if.wline = 32'hFFFF_FFFF;
        tick();
        b_if.wen = 1'b0; b_if.ren = 1'b1; b_if.raddr = 7'd99;
        tick();
        checks++;
        if (b_if.rline !== 32'h0000_0063) begin
            errors++;
            $display("FAIL np2_last_line: got %h want %h", b_if.rline, 32'h0000_0063);
        end
        b_if.raddr = 7'd120;
        tick();
        checks++;
        if (b_if.rline !== 32'h0) begin
            errors++;
            $display("FAIL np2_oob_read: got %h want %h", b_if.rline, 32'h0);
        end
        b_if.raddr = 7'd20;
        tick();
        checks++;
        if (b_if.rline !== 32'h0000_ABCD) begin
            errors++;
            $display("FAIL np2_line20: got %h want %h", b_if.rline, 32'h0000_ABCD);
        end
        b_if.ren = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        a_if.wen = 1'b0; a_if.waddr = '0; a_if.wline = '0; a_if.ren = 1'b0; a_if.raddr = '0;
        b_if.wen = 1'b0; b_if.waddr = '0; b_if.wline = '0; b_if.ren = 1'b0; b_if.raddr = '0;
        tick();
        tick();
        test_reset();
        test_basic();
        test_hold();
        test_collision();
        test_back_to_back();
        test_non_pow2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
